ray_nearest_hit_scheduler: RTL and testbench
============================================

// Module: ray_nearest_hit_scheduler
// PURPOSE
//  Sequences one ray against every object in the scene list through ray_unified_intersection_pipeline.
//  Issues one object per cycle, counts the in-order results, and keeps the nearest valid hit.
//  Reports {hit, object index, distance} per ray to the shading stage.
//  Sits between the ray generator / object RAM and the intersection pipeline.
// PARAMETERS
//  IDX_W       8           object index width; scene list holds up to 2**IDX_W objects
//  PIPE_DEPTH  84          cycles to flush the intersection pipeline after reset (>= pipeline latency)
//  MIN_DIST    32'h0000_4000  self-hit epsilon, Q8.24; hits with dist <= MIN_DIST are discarded
// PORTS
//  clk                 in   1        clock
//  rst                 in   1        synchronous reset, active-high
//  ray_valid           in   1        ray request valid
//  ray_ready           out  1        scheduler can accept a ray
//  ray_origin          in   96       {z,y,x} signed Q8.24
//  ray_direction       in   96       {z,y,x} signed Q8.24, unit length
//  num_objects         in   IDX_W+1  object count for this ray, 0..2**IDX_W
//  obj_addr            out  IDX_W    object RAM read address
//  obj_rd              out  1        object RAM read strobe
//  obj_type            in   1        RAM data, 1 cycle after obj_rd: 0=sphere, 1=plane
//  obj_pos             in   96       sphere centre / plane origin
//  obj_vec             in   96       plane normal (unused for sphere)
//  obj_r2              in   32       sphere radius squared (unused for plane)
//  pipe_new_data       out  1        issue strobe to pipeline
//  pipe_obj_type       out  1        to pipeline input_obj_type
//  pipe_ray_origin     out  96       held ray origin
//  pipe_ray_direction  out  96       held ray direction
//  pipe_plane_origin   out  96       = obj_pos
//  pipe_plane_normal   out  96       = obj_vec
//  pipe_sphere_center  out  96       = obj_pos
//  pipe_sphere_r2      out  32       = obj_r2
//  pipe_was_hit        in   1        pipeline was_hit
//  pipe_hit_dist       in   32       pipeline hit_dist, signed Q8.24
//  pipe_output_valid   in   1        pipeline output_valid; results return in issue order
//  res_valid           out  1        result valid; held until res_ready
//  res_ready           in   1        consumer accepts result
//  res_hit             out  1        at least one accepted hit
//  res_obj_idx         out  IDX_W    index of nearest hit (0 if no hit)
//  res_dist            out  32       nearest distance (32'h7FFF_FFFF if no hit)
// BEHAVIOUR
//  Reset: state=FLUSH; all outputs 0 except res_dist=32'h7FFF_FFFF; flush counter=PIPE_DEPTH.
//  FLUSH: ray_ready=0; pipe_output_valid ignored; after PIPE_DEPTH cycles -> IDLE (drops stale results).
//  IDLE: ray_ready=1. On ray_valid&ray_ready, latch ray and num_objects, clear best (res_dist=7FFF_FFFF, res_hit=0),
//    issue_cnt=ret_cnt=0. If num_objects==0 -> DONE next cycle, else -> ISSUE.
//  ISSUE: obj_rd=1, obj_addr=issue_cnt, issue_cnt++ each cycle; after addr num_objects-1 -> DRAIN.
//  Issue path: pipe_new_data = obj_rd delayed 1 cycle, aligned with RAM data; object fields wired
//    combinationally from RAM outputs; ray fields from latched registers. One object per cycle, no gaps.
//  Return path (ISSUE or DRAIN): each pipe_output_valid, ret_cnt++. If was_hit & signed dist>MIN_DIST &
//    dist<res_dist (strict, signed), update res_dist, res_obj_idx=ret_cnt, res_hit=1. Ties keep lower index.
//  DRAIN: when ret_cnt reaches num_objects (incl. same-cycle final return) -> DONE next cycle.
//  DONE: res_valid=1, outputs stable until res_ready; on res_valid&res_ready -> IDLE (same cycle ray_ready).
//  pipe_output_valid in IDLE/DONE is ignored (does not count).
//  num_objects==2**IDX_W: issue_cnt wraps to 0 only after last issue; counters are IDX_W+1 bits.
//  rst during any state: abort ray, no result emitted, re-enter FLUSH.
//  Latency per ray (N>0): N + PIPE_LAT + 2 cycles from accept to res_valid.
// TESTING (bench uses a fixed-latency pipeline model, latency 83, scripted per-index results)
//  Reset then ray: ray_ready low 84 cycles, high after; stale output_valid during flush ignored.
//  N=3, hits dist {2.0,1.5,1.5} (0x02000000,0x01800000,0x01800000) -> res_hit=1, idx=1, dist=0x01800000.
//  N=2, was_hit={0,0} -> res_hit=0, idx=0, dist=0x7FFFFFFF; N=0 -> same result 2 cycles after accept.
//  N=2 hits {0x00002000 (<=MIN_DIST), 0x01BB67AE} -> idx=1, dist=0x01BB67AE.
//  Issue check: N=4 -> obj_addr 0..3 on consecutive cycles, pipe_new_data 4 contiguous cycles, 1 cycle later.
//  Hold res_ready=0 10 cycles -> res_* stable, ray_ready=0; rst mid-ISSUE -> no res_valid, FLUSH re-run.

Source files
------------

// File: rtl/ray_nearest_hit_scheduler.sv
// Nearest-hit scheduler: streams one ray against the object list through the intersection
// pipeline, counts in-order returns and keeps the closest accepted hit for the shading stage.
module ray_nearest_hit_scheduler #(
  parameter int          IDX_W      = 8,
  parameter int          PIPE_DEPTH = 84,
  parameter logic [31:0] MIN_DIST   = 32'h0000_4000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ray_valid,
  output logic             ray_ready,
  input  logic [95:0]      ray_origin,
  input  logic [95:0]      ray_direction,
  input  logic [IDX_W:0]   num_objects,
  output logic [IDX_W-1:0] obj_addr,
  output logic             obj_rd,
  input  logic             obj_type,
  input  logic [95:0]      obj_pos,
  input  logic [95:0]      obj_vec,
  input  logic [31:0]      obj_r2,
  output logic             pipe_new_data,
  output logic             pipe_obj_type,
  output logic [95:0]      pipe_ray_origin,
  output logic [95:0]      pipe_ray_direction,
  output logic [95:0]      pipe_plane_origin,
  output logic [95:0]      pipe_plane_normal,
  output logic [95:0]      pipe_sphere_center,
  output logic [31:0]      pipe_sphere_r2,
  input  logic             pipe_was_hit,
  input  logic [31:0]      pipe_hit_dist,
  input  logic             pipe_output_valid,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_hit,
  output logic [IDX_W-1:0] res_obj_idx,
  output logic [31:0]      res_dist
);

  // state  | meaning
  // FLUSH  | waiting out stale pipeline results after reset
  // IDLE   | ready for a new ray
  // ISSUE  | reading one object per cycle and feeding the pipeline
  // DRAIN  | all objects issued, waiting for the remaining returns
  // DONE   | result presented until the consumer takes it
  typedef enum logic [2:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam int               FL_W      = $clog2(PIPE_DEPTH + 1);
  localparam logic [FL_W-1:0]  FL_INIT   = FL_W'(PIPE_DEPTH);
  localparam logic [FL_W-1:0]  FL_ONE    = FL_W'(1);
  localparam logic [IDX_W:0]   CNT_ONE   = (IDX_W + 1)'(1);
  localparam logic [31:0]      DIST_NONE = 32'h7FFF_FFFF;

  state_e           state_q, state_d;
  logic [FL_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [IDX_W:0]   num_q, num_d;
  logic [IDX_W:0]   issue_cnt_q, issue_cnt_d;
  logic [IDX_W:0]   ret_cnt_q, ret_cnt_d;
  logic [95:0]      origin_q, origin_d;
  logic [95:0]      dir_q, dir_d;
  logic             best_hit_q, best_hit_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [31:0]      best_dist_q, best_dist_d;
  logic             new_data_q, new_data_d;
  logic             hit_ok;
  logic             returning;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    num_d       = num_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    origin_d    = origin_q;
    dir_d       = dir_q;
    best_hit_d  = best_hit_q;
    best_idx_d  = best_idx_q;
    best_dist_d = best_dist_q;
    new_data_d  = (state_q == ST_ISSUE);

    // Strict compare against the current best keeps the lower index on ties.
    hit_ok = pipe_was_hit
             && ($signed(pipe_hit_dist) > $signed(MIN_DIST))
             && ($signed(pipe_hit_dist) < $signed(best_dist_q));
    returning = pipe_output_valid && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));

    case (state_q)
      ST_FLUSH: begin
        if (flush_cnt_q <= FL_ONE) begin
          flush_cnt_d = '0;
          state_d     = ST_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - FL_ONE;
        end
      end
      ST_IDLE: begin
        if (ray_valid) begin
          origin_d    = ray_origin;
          dir_d       = ray_direction;
          num_d       = num_objects;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
          best_hit_d  = 1'b0;
          best_idx_d  = '0;
          best_dist_d = DIST_NONE;
          // An empty scene passes through DRAIN, where the zero count completes at once.
          state_d     = (num_objects == '0) ? ST_DRAIN : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (issue_cnt_q == (num_q - CNT_ONE)) begin
          issue_cnt_d = '0;
          state_d     = ST_DRAIN;
        end else begin
          issue_cnt_d = issue_cnt_q + CNT_ONE;
        end
      end
      ST_DRAIN: begin
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_FLUSH;
    endcase

    if (returning) begin
      ret_cnt_d = ret_cnt_q + CNT_ONE;
      if (hit_ok) begin
        best_hit_d  = 1'b1;
        best_idx_d  = ret_cnt_q[IDX_W-1:0];
        best_dist_d = pipe_hit_dist;
      end
    end

    if ((state_q == ST_DRAIN) && (ret_cnt_d == num_q)) state_d = ST_DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FLUSH;
      flush_cnt_q <= FL_INIT;
      num_q       <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      origin_q    <= '0;
      dir_q       <= '0;
      best_hit_q  <= 1'b0;
      best_idx_q  <= '0;
      best_dist_q <= DIST_NONE;
      new_data_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      num_q       <= num_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      origin_q    <= origin_d;
      dir_q       <= dir_d;
      best_hit_q  <= best_hit_d;
      best_idx_q  <= best_idx_d;
      best_dist_q <= best_dist_d;
      new_data_q  <= new_data_d;
    end
  end

  assign ray_ready = (state_q == ST_IDLE);
  assign obj_rd    = (state_q == ST_ISSUE);
  assign obj_addr  = issue_cnt_q[IDX_W-1:0];

  // Object fields arrive from the RAM one cycle after the read, in step with new_data_q.
  assign pipe_new_data      = new_data_q;
  assign pipe_obj_type      = obj_type;
  assign pipe_ray_origin    = origin_q;
  assign pipe_ray_direction = dir_q;
  assign pipe_plane_origin  = obj_pos;
  assign pipe_plane_normal  = obj_vec;
  assign pipe_sphere_center = obj_pos;
  assign pipe_sphere_r2     = obj_r2;

  assign res_valid   = (state_q == ST_DONE);
  assign res_hit     = best_hit_q;
  assign res_obj_idx = best_idx_q;
  assign res_dist    = best_dist_q;

endmodule

// File: tb/tb_ray_nearest_hit_scheduler.sv
// Bench for ray_nearest_hit_scheduler: object RAM and fixed-latency pipeline models with
// per-index scripted results, directed boundary rays and randomized rays against a reference.
module tb_ray_nearest_hit_scheduler;
  localparam int          IDX_W    = 8;
  localparam int          PIPE_LAT = 83;
  localparam logic [31:0] MIN_DIST = 32'h0000_4000;
  localparam logic [31:0] NONE     = 32'h7FFF_FFFF;

  logic             clk = 1'b0;
  logic             rst;
  logic             ray_valid;
  logic             ray_ready;
  logic [95:0]      ray_origin;
  logic [95:0]      ray_direction;
  logic [IDX_W:0]   num_objects;
  logic [IDX_W-1:0] obj_addr;
  logic             obj_rd;
  logic             obj_type;
  logic [95:0]      obj_pos;
  logic [95:0]      obj_vec;
  logic [31:0]      obj_r2;
  logic             pipe_new_data;
  logic             pipe_obj_type;
  logic [95:0]      pipe_ray_origin;
  logic [95:0]      pipe_ray_direction;
  logic [95:0]      pipe_plane_origin;
  logic [95:0]      pipe_plane_normal;
  logic [95:0]      pipe_sphere_center;
  logic [31:0]      pipe_sphere_r2;
  logic             pipe_was_hit;
  logic [31:0]      pipe_hit_dist;
  logic             pipe_output_valid;
  logic             res_valid;
  logic             res_ready;
  logic             res_hit;
  logic [IDX_W-1:0] res_obj_idx;
  logic [31:0]      res_dist;

  int checks = 0;
  int errors = 0;

  logic        hit_tab  [256];
  logic [31:0] dist_tab [256];
  logic [95:0] cur_origin, cur_dir;
  logic        stale_inj;
  int          field_err_cnt = 0;

  logic [PIPE_LAT-1:0] v_sr = '0;
  logic [PIPE_LAT-1:0] h_sr = '0;
  logic [31:0]         d_sr [PIPE_LAT];

  always #5 clk = ~clk;

  ray_nearest_hit_scheduler dut (
    .clk(clk), .rst(rst), .ray_valid(ray_valid), .ray_ready(ray_ready),
    .ray_origin(ray_origin), .ray_direction(ray_direction), .num_objects(num_objects),
    .obj_addr(obj_addr), .obj_rd(obj_rd), .obj_type(obj_type), .obj_pos(obj_pos),
    .obj_vec(obj_vec), .obj_r2(obj_r2), .pipe_new_data(pipe_new_data),
    .pipe_obj_type(pipe_obj_type), .pipe_ray_origin(pipe_ray_origin),
    .pipe_ray_direction(pipe_ray_direction), .pipe_plane_origin(pipe_plane_origin),
    .pipe_plane_normal(pipe_plane_normal), .pipe_sphere_center(pipe_sphere_center),
    .pipe_sphere_r2(pipe_sphere_r2), .pipe_was_hit(pipe_was_hit),
    .pipe_hit_dist(pipe_hit_dist), .pipe_output_valid(pipe_output_valid),
    .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit),
    .res_obj_idx(res_obj_idx), .res_dist(res_dist)
  );

  // Object RAM: one-cycle read, contents derived from the address so the index travels with it.
  always @(posedge clk) begin
    if (obj_rd) begin
      obj_type <= obj_addr[0];
      obj_pos  <= {3{24'h5A5A5A, obj_addr}};
      obj_vec  <= {3{24'hC3C3C3, obj_addr}};
      obj_r2   <= {24'h0, obj_addr};
    end
  end

  // Pipeline: fixed latency, result looked up from the scripted per-index tables at issue.
  always @(posedge clk) begin
    v_sr <= {v_sr[PIPE_LAT-2:0], pipe_new_data};
    h_sr <= {h_sr[PIPE_LAT-2:0], hit_tab[pipe_sphere_r2[7:0]]};
    for (int i = PIPE_LAT - 1; i > 0; i--) d_sr[i] <= d_sr[i-1];
    d_sr[0] <= dist_tab[pipe_sphere_r2[7:0]];
    if (pipe_new_data) begin
      if (pipe_ray_origin !== cur_origin || pipe_ray_direction !== cur_dir
          || pipe_obj_type !== pipe_sphere_r2[0]
          || pipe_sphere_center !== {3{24'h5A5A5A, pipe_sphere_r2[7:0]}}
          || pipe_plane_origin !== {3{24'h5A5A5A, pipe_sphere_r2[7:0]}}
          || pipe_plane_normal !== {3{24'hC3C3C3, pipe_sphere_r2[7:0]}})
        field_err_cnt <= field_err_cnt + 1;
    end
  end

  // Stale results (injected) look like an attractive near hit, so counting them would show.
  assign pipe_output_valid = v_sr[PIPE_LAT-1] | stale_inj;
  assign pipe_was_hit      = stale_inj ? 1'b1 : h_sr[PIPE_LAT-1];
  assign pipe_hit_dist     = stale_inj ? 32'h0001_0000 : d_sr[PIPE_LAT-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: smallest qualifying distance, then the first index holding it.
  function automatic void ref_nearest(input int n, output logic h, output logic [7:0] idx,
                                      output logic [31:0] d);
    logic signed [31:0] m;
    bit any;
    bit found;
    m = NONE; any = 0; found = 0; idx = '0;
    for (int i = 0; i < n; i++)
      if (hit_tab[i] && $signed(dist_tab[i]) > $signed(MIN_DIST) && $signed(dist_tab[i]) < $signed(NONE))
        if (!any || $signed(dist_tab[i]) < m) begin m = dist_tab[i]; any = 1; end
    for (int i = 0; i < n; i++)
      if (any && !found && hit_tab[i] && dist_tab[i] == m) begin idx = 8'(i); found = 1; end
    h = any;
    d = any ? m : NONE;
  endfunction

  function automatic logic [31:0] rand_dist();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_3FFF + $urandom_range(0, 2);
      1:       return 32'h8000_0000 | $urandom;
      2:       return 32'h0100_0000 + $urandom_range(0, 3) * 32'h0040_0000;
      default: return {4'h0, 28'($urandom)};
    endcase
  endfunction

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      hit_tab[i]  = ($urandom_range(0, 9) < 7);
      dist_tab[i] = rand_dist();
    end
  endtask

  task automatic wait_ready(input string tag);
    int w;
    w = 0;
    @(negedge clk);
    while (!ray_ready && w < 400) begin @(negedge clk); w++; end
    if (!ray_ready) check({tag, "_ready_timeout"}, 64'(ray_ready), 64'(1));
  endtask

  task automatic run_ray(input string tag, input int n, input int hold,
                         output logic g_hit, output logic [7:0] g_idx, output logic [31:0] g_dist);
    logic        eh;
    logic [7:0]  ei;
    logic [31:0] ed;
    int lat, rd, nd, fb0, exp_lat;
    bit iss_ok, hold_ok;
    logic [7:0] ea;
    wait_ready(tag);
    ref_nearest(n, eh, ei, ed);
    cur_origin    = {$urandom, $urandom, $urandom};
    cur_dir       = {$urandom, $urandom, $urandom};
    ray_origin    = cur_origin;
    ray_direction = cur_dir;
    num_objects   = 9'(n);
    ray_valid     = 1'b1;
    fb0 = field_err_cnt;
    @(posedge clk);
    #1;
    ray_valid     = 1'b0;
    ray_origin    = {$urandom, $urandom, $urandom};
    ray_direction = {$urandom, $urandom, $urandom};
    lat = 0; rd = 0; nd = 0; iss_ok = 1;
    do begin
      @(negedge clk);
      lat++;
      if (obj_rd) begin
        ea = 8'(lat - 1);
        if (obj_addr !== ea || lat > n) iss_ok = 0;
        rd++;
      end
      if (pipe_new_data) begin
        if (lat != nd + 2) iss_ok = 0;
        nd++;
      end
    end while (!res_valid && lat < n + 300);
    exp_lat = (n > 0) ? n + PIPE_LAT + 2 : 2;
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res_hit"}, 64'(res_hit), 64'(eh));
    check({tag, "_res_idx"}, 64'(res_obj_idx), 64'(ei));
    check({tag, "_res_dist"}, 64'(res_dist), 64'(ed));
    check({tag, "_issue_seq"}, {32'(iss_ok), 16'(rd), 16'(nd)}, {32'd1, 16'(n), 16'(n)});
    check({tag, "_pipe_fields"}, 64'(field_err_cnt - fb0), 64'(0));
    g_hit = res_hit; g_idx = res_obj_idx; g_dist = res_dist;
    if (hold > 0) begin
      hold_ok = 1;
      stale_inj = 1'b1;
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        if (!res_valid || ray_ready || res_hit !== g_hit || res_obj_idx !== g_idx || res_dist !== g_dist)
          hold_ok = 0;
      end
      stale_inj = 1'b0;
      @(negedge clk);
      check({tag, "_hold_stable"}, 64'(hold_ok), 64'(1));
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    check({tag, "_handshake"}, {32'(res_valid), 32'(ray_ready)}, {32'd0, 32'd1});
  endtask

  task automatic flush_count(input string tag, input bit inject);
    int cnt;
    bit seen;
    cnt = 0; seen = 0;
    stale_inj = inject;
    do begin
      @(negedge clk);
      cnt++;
      if (res_valid) seen = 1;
      if (cnt == 40) stale_inj = 1'b0;
    end while (!ray_ready && cnt < 300);
    stale_inj = 1'b0;
    check({tag, "_flush_len"}, 64'(cnt), 64'(84));
    check({tag, "_flush_no_result"}, 64'(seen), 64'(0));
  endtask

  initial begin
    logic        gh;
    logic [7:0]  gi;
    logic [31:0] gd;
    int n;
    rst = 1'b1; ray_valid = 1'b0; ray_origin = '0; ray_direction = '0; num_objects = '0;
    res_ready = 1'b0; stale_inj = 1'b0; cur_origin = '0; cur_dir = '0;
    for (int i = 0; i < 256; i++) begin hit_tab[i] = 1'b0; dist_tab[i] = NONE; end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {16'(ray_ready), 16'(res_valid), 16'(obj_rd), 16'(pipe_new_data)}, 64'(0));
    check("reset_res", {16'(res_hit), 16'(res_obj_idx), res_dist}, {16'd0, 16'd0, NONE});
    rst = 1'b0;
    flush_count("init", 1'b1);

    hit_tab[0] = 1; dist_tab[0] = 32'h0200_0000;
    hit_tab[1] = 1; dist_tab[1] = 32'h0180_0000;
    hit_tab[2] = 1; dist_tab[2] = 32'h0180_0000;
    run_ray("tie", 3, 0, gh, gi, gd);
    check("tie_const", {gh, 23'd0, gi, gd}, {1'b1, 23'd0, 8'd1, 32'h0180_0000});

    stale_inj = 1'b1;
    repeat (3) @(negedge clk);
    stale_inj = 1'b0;
    hit_tab[0] = 0; dist_tab[0] = 32'h0100_0000;
    hit_tab[1] = 0; dist_tab[1] = 32'h0100_0000;
    run_ray("nohit", 2, 0, gh, gi, gd);
    check("nohit_const", {gh, 23'd0, gi, gd}, {1'b0, 23'd0, 8'd0, NONE});

    run_ray("empty", 0, 0, gh, gi, gd);
    check("empty_const", {gh, 23'd0, gi, gd}, {1'b0, 23'd0, 8'd0, NONE});

    hit_tab[0] = 1; dist_tab[0] = 32'h0000_2000;
    hit_tab[1] = 1; dist_tab[1] = 32'h01BB_67AE;
    run_ray("eps", 2, 0, gh, gi, gd);
    check("eps_const", {gh, 23'd0, gi, gd}, {1'b1, 23'd0, 8'd1, 32'h01BB_67AE});

    hit_tab[0] = 1; dist_tab[0] = 32'h0300_0000;
    hit_tab[1] = 1; dist_tab[1] = 32'hFFFF_FFFF;
    hit_tab[2] = 1; dist_tab[2] = 32'h0000_4000;
    hit_tab[3] = 1; dist_tab[3] = 32'h0000_4001;
    run_ray("issue4", 4, 10, gh, gi, gd);
    check("issue4_const", {gh, 23'd0, gi, gd}, {1'b1, 23'd0, 8'd3, 32'h0000_4001});

    fill_random(20);
    wait_ready("abort");
    cur_origin = {$urandom, $urandom, $urandom};
    cur_dir    = {$urandom, $urandom, $urandom};
    ray_origin = cur_origin; ray_direction = cur_dir; num_objects = 9'd20; ray_valid = 1'b1;
    @(posedge clk);
    #1;
    ray_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    flush_count("abort", 1'b0);

    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 24);
      fill_random(n);
      run_ray("rand", n, (r == 3) ? 4 : 0, gh, gi, gd);
    end

    fill_random(256);
    run_ray("full", 256, 0, gh, gi, gd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
